axis_frame_gen: RTL and testbench

//   AXI4-Stream master (transmitter) that builds whole frames from a one-beat command and drives them into
//   an AXIS sink (e.g. axis_reg or a DUT slave port). Payload is a deterministic incrementing byte pattern

---
 rtl/axis_frame_gen.sv | 152 +++++++++++++++
 tb/tb_axis_frame_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: turns a one-beat command into a whole frame
// whose payload is an incrementing byte pattern starting at the command seed.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// STATE_IDLE | cmd_ready high, waiting for a command; no beat presented
// STATE_SEND | frame in flight, one beat advanced per tvalid & tready
module axis_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [7:0]            cmd_seed,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic                  done,
  output logic                  len_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SEND = 1'b1;

  localparam logic [LEN_WIDTH-1:0] KEEP_L = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L  = LEN_WIDTH'(1);

  logic [0:0]            state;
  // Beats still to send after the one currently presented; LEN_WIDTH bits
  // always hold the beat count since a beat is at least one byte.
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [7:0]            base;
  logic [KEEP_WIDTH-1:0] last_keep;

  logic [LEN_WIDTH-1:0]  cmd_rem;
  logic [LEN_WIDTH-1:0]  cmd_beats;
  logic [KEEP_WIDTH-1:0] cmd_last_keep;
  logic [KEEP_WIDTH-1:0] first_keep;
  logic [7:0]            next_base;
  logic [KEEP_WIDTH-1:0] next_keep;
  logic                  cmd_accept;
  logic                  beat_xfer;

  // Payload for one beat: lane i carries base+i, disabled lanes are zero.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0] b,
                                                      input logic [KEEP_WIDTH-1:0] keep);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (keep[i]) d[8*i +: 8] = b + 8'(i);
    end
    return d;
  endfunction

  // Command decode: beat count and keep mask for the final beat.
  always_comb begin
    cmd_rem       = cmd_len % KEEP_L;
    cmd_beats     = (cmd_len / KEEP_L) + {{(LEN_WIDTH-1){1'b0}}, (cmd_rem != '0)};
    cmd_last_keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cmd_last_keep[i] = (cmd_rem == '0) || (LEN_WIDTH'(i) < cmd_rem);
    end
    first_keep = (cmd_beats == ONE_L) ? cmd_last_keep : '1;
    next_base  = base + 8'(KEEP_WIDTH);
    next_keep  = (beats_left == ONE_L) ? last_keep : '1;
    cmd_accept = cmd_valid && cmd_ready;
    beat_xfer  = m_axis_tvalid && m_axis_tready;
  end

  // Frame sequencing and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STATE_IDLE;
      beats_left    <= '0;
      base          <= '0;
      last_keep     <= '0;
      cmd_ready     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      done          <= 1'b0;
      len_err       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      case (state)
        STATE_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_accept) begin
            if (cmd_len == '0) begin
              len_err <= 1'b1;
            end else begin
              state         <= STATE_SEND;
              cmd_ready     <= 1'b0;
              beats_left    <= cmd_beats - ONE_L;
              base          <= cmd_seed;
              last_keep     <= cmd_last_keep;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= beat_data(cmd_seed, first_keep);
              m_axis_tkeep  <= first_keep;
              m_axis_tlast  <= (cmd_beats == ONE_L);
              m_axis_tuser  <= USER_WIDTH'(1);
              m_axis_tid    <= cmd_id;
              m_axis_tdest  <= cmd_dest;
            end
          end
        end
        default: begin
          if (beat_xfer) begin
            if (m_axis_tlast) begin
              state         <= STATE_IDLE;
              cmd_ready     <= 1'b1;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tuser  <= '0;
              done          <= 1'b1;
              frame_cnt     <= frame_cnt + 16'd1;
            end else begin
              beats_left   <= beats_left - ONE_L;
              base         <= next_base;
              m_axis_tdata <= beat_data(next_base, next_keep);
              m_axis_tkeep <= next_keep;
              m_axis_tlast <= (beats_left == ONE_L);
              m_axis_tuser <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen with a 32-bit stream: directed frames plus random
// frames and random backpressure, checked against an arithmetic byte model.
module tb_axis_frame_gen;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [7:0]    cmd_seed = '0;
  logic [7:0]    cmd_id = '0;
  logic [7:0]    cmd_dest = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [KW-1:0] m_axis_tkeep;
  logic [0:0]    m_axis_tuser;
  logic [7:0]    m_axis_tid;
  logic [7:0]    m_axis_tdest;
  logic          done;
  logic          len_err;
  logic [15:0]   frame_cnt;

  axis_frame_gen #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW),
    .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_seed(cmd_seed), .cmd_id(cmd_id), .cmd_dest(cmd_dest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .done(done), .len_err(len_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;
  int timeouts = 0;
  int stall_viol;
  int bubbles;
  logic done_after, tvalid_after, done_next;

  logic [DW-1:0] cap_data[$];
  logic [KW-1:0] cap_keep[$];
  logic          cap_last[$];
  logic          cap_user[$];
  logic [7:0]    cap_id[$];
  logic [7:0]    cap_dest[$];

  // Reference model: beat b of a len-byte frame holds bytes seed+4b+i.
  function automatic logic [KW-1:0] exp_keep(input int len, input int b);
    int n = (len + KW - 1) / KW;
    int r = len % KW;
    if (b == n - 1 && r != 0) return KW'((1 << r) - 1);
    return '1;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int len, input int seed, input int b);
    logic [KW-1:0] k = exp_keep(len, b);
    logic [DW-1:0] d = '0;
    for (int i = 0; i < KW; i++)
      if (k[i]) d[8*i +: 8] = 8'((seed + b * KW + i) % 256);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic [7:0] id,
                          input logic [7:0] dest);
    int n = 0;
    cmd_len = LW'(len); cmd_seed = seed; cmd_id = id; cmd_dest = dest; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) timeouts++;
    tick();
    cmd_valid = 1'b0;
    cmd_len = LW'($urandom); cmd_seed = 8'($urandom);
    cmd_id = 8'($urandom); cmd_dest = 8'($urandom);
  endtask

  task automatic collect(input int rdy_pct);
    int cyc = 0;
    bit got_last = 0;
    bit held = 0;
    logic [DW-1:0] hd; logic [KW-1:0] hk; logic hl, hu;
    cap_data.delete(); cap_keep.delete(); cap_last.delete();
    cap_user.delete(); cap_id.delete(); cap_dest.delete();
    stall_viol = 0; bubbles = 0;
    while (!got_last && cyc < 2000) begin
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      if (!m_axis_tvalid) bubbles++;
      else if (held && (m_axis_tdata !== hd || m_axis_tkeep !== hk ||
                        m_axis_tlast !== hl || m_axis_tuser[0] !== hu)) stall_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data.push_back(m_axis_tdata); cap_keep.push_back(m_axis_tkeep);
        cap_last.push_back(m_axis_tlast); cap_user.push_back(m_axis_tuser[0]);
        cap_id.push_back(m_axis_tid);     cap_dest.push_back(m_axis_tdest);
        held = 0;
        if (m_axis_tlast) got_last = 1;
      end else if (m_axis_tvalid) begin
        held = 1; hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast; hu = m_axis_tuser[0];
      end
      tick(); cyc++;
    end
    if (!got_last) timeouts++;
    m_axis_tready = 1'b0;
    done_after = done; tvalid_after = m_axis_tvalid;
    tick();
    done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || m_axis_tvalid !== 1'b0 || done !== 1'b0 ||
        len_err !== 1'b0 || frame_cnt !== 16'd0 || m_axis_tdata !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: cmd_ready=%b tvalid=%b done=%b len_err=%b frame_cnt=%0d tdata=%h, required all 0",
               cmd_ready, m_axis_tvalid, done, len_err, frame_cnt, m_axis_tdata);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready_early: cmd_ready=%b required 0", cmd_ready);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready_rise: cmd_ready=%b required 1", cmd_ready);
    end
    exp_frames = 0;
  endtask

  task automatic test_two_beat();
    logic [31:0] ed[2] = '{32'h13121110, 32'h17161514};
    send_cmd(8, 8'h10, 8'h01, 8'h02);
    collect(100);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 2) begin
      n_errors++; $display("FAIL two_beat_count: got %0d beats required 2", cap_data.size());
    end else begin
      for (int b = 0; b < 2; b++) begin
        n_checks++;
        if (cap_data[b] !== ed[b] || cap_keep[b] !== 4'hF || cap_user[b] !== (b == 0) ||
            cap_last[b] !== (b == 1)) begin
          n_errors++;
          $display("FAIL two_beat_%0d: data=%h keep=%h user=%b last=%b required data=%h keep=f user=%b last=%b",
                   b, cap_data[b], cap_keep[b], cap_user[b], cap_last[b], ed[b], b == 0, b == 1);
        end
      end
    end
    n_checks++;
    if (bubbles != 0 || done_after !== 1'b1 || tvalid_after !== 1'b0 || done_next !== 1'b0) begin
      n_errors++;
      $display("FAIL two_beat_timing: bubbles=%0d done=%b tvalid_after=%b done_next=%b required 0/1/0/0",
               bubbles, done_after, tvalid_after, done_next);
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      n_errors++; $display("FAIL two_beat_cnt: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_partial();
    send_cmd(5, 8'h10, 8'h00, 8'h00);
    collect(100);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 2 || cap_data[1] !== 32'h00000014 || cap_keep[1] !== 4'h1 ||
        cap_last[1] !== 1'b1 || cap_last[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL partial_len5: beats=%0d data1=%h keep1=%h last1=%b, required 2/00000014/1/1",
               cap_data.size(), cap_data[1], cap_keep[1], cap_last[1]);
    end
    send_cmd(4, 8'h10, 8'h00, 8'h00);
    collect(100);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 1 || cap_keep[0] !== 4'hF || cap_last[0] !== 1'b1 ||
        cap_user[0] !== 1'b1 || cap_data[0] !== 32'h13121110) begin
      n_errors++;
      $display("FAIL partial_len4: beats=%0d data=%h keep=%h last=%b user=%b, required 1/13121110/f/1/1",
               cap_data.size(), cap_data[0], cap_keep[0], cap_last[0], cap_user[0]);
    end
  endtask

  task automatic test_stall();
    send_cmd(16, 8'h33, 8'h07, 8'h09);
    collect(50);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 4 || stall_viol != 0) begin
      n_errors++;
      $display("FAIL stall_count: beats=%0d stall_changes=%0d required 4/0", cap_data.size(), stall_viol);
    end
    for (int b = 0; b < cap_data.size(); b++) begin
      n_checks++;
      if (cap_data[b] !== exp_data(16, 'h33, b) || cap_last[b] !== (b == 3)) begin
        n_errors++;
        $display("FAIL stall_beat_%0d: data=%h last=%b required %h/%b",
                 b, cap_data[b], cap_last[b], exp_data(16, 'h33, b), b == 3);
      end
    end
  endtask

  task automatic test_seed_wrap();
    send_cmd(4, 8'hFE, 8'hA5, 8'h3C);
    collect(100);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 32'h0100FFFE || cap_id[0] !== 8'hA5 ||
        cap_dest[0] !== 8'h3C) begin
      n_errors++;
      $display("FAIL seed_wrap: beats=%0d data=%h id=%h dest=%h required 1/0100fffe/a5/3c",
               cap_data.size(), cap_data[0], cap_id[0], cap_dest[0]);
    end
  endtask

  task automatic test_len_zero();
    cmd_len = '0; cmd_seed = 8'h55; cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL len0_ready: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (len_err !== 1'b1 || m_axis_tvalid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL len0_pulse: len_err=%b tvalid=%b done=%b cmd_ready=%b required 1/0/0/1",
               len_err, m_axis_tvalid, done, cmd_ready);
    end
    tick();
    n_checks++;
    if (len_err !== 1'b0 || m_axis_tvalid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_errors++;
      $display("FAIL len0_after: len_err=%b tvalid=%b frame_cnt=%0d required 0/0/%0d",
               len_err, m_axis_tvalid, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 10; f++) begin
      int len = $urandom_range(1, 40);
      int seed = $urandom_range(0, 255);
      int pct = $urandom_range(30, 100);
      logic [7:0] id = 8'($urandom);
      logic [7:0] dest = 8'($urandom);
      int nb = (len + KW - 1) / KW;
      send_cmd(len, 8'(seed), id, dest);
      collect(pct);
      exp_frames++;
      n_checks++;
      if (cap_data.size() != nb || stall_viol != 0 || done_after !== 1'b1 || done_next !== 1'b0) begin
        n_errors++;
        $display("FAIL rand_frame_%0d: beats=%0d stall_changes=%0d done=%b done_next=%b required %0d/0/1/0",
                 f, cap_data.size(), stall_viol, done_after, done_next, nb);
      end
      for (int b = 0; b < cap_data.size(); b++) begin
        n_checks++;
        if (cap_data[b] !== exp_data(len, seed, b) || cap_keep[b] !== exp_keep(len, b) ||
            cap_last[b] !== (b == nb - 1) || cap_user[b] !== (b == 0) ||
            cap_id[b] !== id || cap_dest[b] !== dest) begin
          n_errors++;
          $display("FAIL rand_beat_%0d_%0d: data=%h keep=%h last=%b user=%b id=%h dest=%h required %h/%h/%b/%b/%h/%h",
                   f, b, cap_data[b], cap_keep[b], cap_last[b], cap_user[b], cap_id[b], cap_dest[b],
                   exp_data(len, seed, b), exp_keep(len, b), b == nb - 1, b == 0, id, dest);
        end
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
        n_errors++; $display("FAIL rand_cnt_%0d: frame_cnt=%0d required %0d", f, frame_cnt, exp_frames);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_cmd(16, 8'h20, 8'h11, 8'h22);
    m_axis_tready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data(16, 'h20, 2)) begin
      n_errors++;
      $display("FAIL midrst_beat2: tvalid=%b data=%h required 1/%h",
               m_axis_tvalid, m_axis_tdata, exp_data(16, 'h20, 2));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || frame_cnt !== 16'd0 || cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_async: tvalid=%b frame_cnt=%0d cmd_ready=%b required 0/0/0",
               m_axis_tvalid, frame_cnt, cmd_ready);
    end
    m_axis_tready = 1'b0;
    exp_frames = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    send_cmd(8, 8'h40, 8'h33, 8'h44);
    collect(100);
    exp_frames++;
    n_checks++;
    if (cap_data.size() != 2 || cap_data[0] !== exp_data(8, 'h40, 0) || cap_user[0] !== 1'b1 ||
        cap_data[1] !== exp_data(8, 'h40, 1) || frame_cnt !== 16'(exp_frames)) begin
      n_errors++;
      $display("FAIL midrst_clean: beats=%0d data0=%h user0=%b data1=%h frame_cnt=%0d required 2/%h/1/%h/%0d",
               cap_data.size(), cap_data[0], cap_user[0], cap_data[1], frame_cnt,
               exp_data(8, 'h40, 0), exp_data(8, 'h40, 1), exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_partial();
    test_stall();
    test_seed_wrap();
    test_len_zero();
    test_random_frames();
    test_reset_mid_frame();
    n_checks++;
    if (timeouts != 0) begin
      n_errors++; $display("FAIL wait_bound: %0d waits expired, required 0", timeouts);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
